mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Single-port main-memory scheduler shared by up to NUM_REQ miss/writeback requesters: I-cache refill, D-cache MSHR head entry, store writeback.
- Grants one requester at a time, round-robin.
- Drives the memory request handshake and routes the memory response back to the owning requester.
- Tracks one outstanding transaction; flags responses that exceed a latency bound.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 = I-cache, 1 = D-cache MSHR, 2 = store writeback
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before timeout (1..65535)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request pending
- req_we  in  NUM_REQ  1 = write (posted), 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing as req_addr
- req_ready  out  NUM_REQ  one-hot accept pulse
- resp_valid  out  NUM_REQ  one-hot read-response pulse
- resp_data  out  DATA_W  response data, valid with any resp_valid bit
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  write flag to memory
- mem_req_addr  out  ADDR_W  address to memory
- mem_req_wdata  out  DATA_W  write data to memory
- mem_resp_valid  in  1  read data return
- mem_resp_data  in  DATA_W  read data
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0; state = IDLE; rr_ptr = 0; owner = 0; timeout counter = 0; latched we/addr/wdata = 0.
- Reset mid-transaction aborts it. A later mem_resp_valid from that transaction is ignored as spurious.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid bit is set, grant g = first set index at or after rr_ptr, searching cyclically.
  - Same cycle: req_ready[g] = 1 (combinational from req_valid and rr_ptr).
  - At the edge: latch owner = g and req_we/addr/wdata[g]; rr_ptr <= (g+1) mod NUM_REQ; go to ISSUE.
- ISSUE:
  - mem_req_valid = 1; mem_req_we/addr/wdata = latched values, held stable until the handshake.
  - On mem_req_valid && mem_req_ready: a write goes to IDLE (no response); a read goes to WAIT with the counter cleared.
- WAIT:
  - Counter increments every cycle.
  - On mem_resp_valid: resp_valid[owner] = 1 and resp_data = mem_resp_data for exactly that cycle (combinational pass-through); go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES with no response: set timeout_err (sticky until reset); pulse resp_valid[owner] with resp_data = 0; go to IDLE.
- resp_data is 0 whenever no resp_valid bit is set.
- Latency:
  - Request accepted in cycle T; mem_req_valid asserted from T+1.
  - Minimum read turnaround: response in T+2 if memory is ready at T+1 and responds at T+2.
  - Minimum re-grant after any completion: the cycle after the return to IDLE. There is no same-cycle bypass.
- Simultaneous events:
  - New req_valid during ISSUE/WAIT: no req_ready; requesters hold req_valid and payload until req_ready.
  - mem_resp_valid in IDLE or ISSUE: ignored, no resp_valid.
  - mem_resp_valid in the same cycle the counter reaches TIMEOUT_CYCLES: the response wins; timeout_err is not set.
- Fairness: rr_ptr advances only on grant. A continuously requesting set is served in cyclic order, with no starvation beyond NUM_REQ-1 grants.
- req_ready and resp_valid are each at most one-hot.
- busy = 1 in ISSUE and WAIT.

Test Plan:
- Reset, then single read from requester 1, addr 0x0000_1000; memory ready immediately, responds 3 cycles later with 0xDEADBEEF -> req_ready[1] pulses at T; mem_req_addr = 0x1000 at T+1; resp_valid = 3'b010 and resp_data = 0xDEADBEEF on the response cycle; busy returns to 0 the next cycle.
- All three requesters assert reads continuously from reset, memory answers each after 1 cycle -> grant order 0,1,2,0,1,2; each req_ready is one-hot; no requester is granted twice before the others are served.
- Requester 2 posts a write, addr 0x2000, wdata 0x12345678; mem_req_ready held low 4 cycles -> mem_req_valid/we/addr/wdata stable for all 5 cycles; state returns to IDLE after the handshake; no resp_valid pulse.
- Read issued, no response for 255 cycles -> timeout_err = 1 at cycle 255 of WAIT; resp_valid[owner] pulses with data 0; timeout_err stays 1 across later transactions until rst.
- mem_resp_valid = 1 while IDLE, and again while ISSUE with mem_req_ready = 0 -> no resp_valid, state unchanged.
- rst asserted asynchronously mid-WAIT, then mem_resp_valid pulses after deassertion -> all outputs 0 immediately; stale response ignored; next request is granted starting from rr_ptr = 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin scheduler sharing one memory port among NUM_REQ requesters, one transaction in flight.
// Grant is combinational in IDLE and the request issues the next cycle; requesters hold req_valid until req_ready.
module mem_req_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_we,
   output logic [ADDR_W-1:0]         mem_req_addr,
   output logic [DATA_W-1:0]         mem_req_wdata,
   input  logic                      mem_resp_valid,
   input  logic [DATA_W-1:0]         mem_resp_data,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   grant_idx;
   logic               grant_vld;
   logic               lat_we;
   logic [ADDR_W-1:0]  lat_addr;
   logic [DATA_W-1:0]  lat_wdata;
   logic [CNT_W-1:0]   wait_cnt;
   logic               timeout_q;
   logic               do_grant;
   logic               issue_done;
   logic               resp_fire;
   logic               tmo_fire;
   int                 scan_idx;

   // Scan from the highest offset down so the nearest requester at or after rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (req_valid[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(scan_idx);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      req_ready     = '0;
      resp_valid    = '0;
      resp_data     = '0;
      mem_req_valid = 1'b0;
      do_grant      = 1'b0;
      issue_done    = 1'b0;
      resp_fire     = 1'b0;
      tmo_fire      = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by rst so no accept pulse escapes while reset is held.
            if (grant_vld && !rst) begin
               do_grant             = 1'b1;
               req_ready[grant_idx] = 1'b1;
               state_d              = ISSUE;
            end
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               issue_done = 1'b1;
               state_d    = lat_we ? IDLE : WAIT;
            end
         end
         WAIT: begin
            // wait_cnt holds cycles already spent here, so this is the TIMEOUT_CYCLES-th WAIT cycle.
            if (mem_resp_valid) begin
               resp_fire = 1'b1;
            end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               tmo_fire = 1'b1;
            end
            if (resp_fire || tmo_fire) begin
               resp_valid[owner] = 1'b1;
               resp_data         = resp_fire ? mem_resp_data : '0;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         owner     <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (do_grant) begin
            owner     <= grant_idx;
            lat_we    <= req_we[grant_idx];
            lat_addr  <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            rr_ptr    <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (issue_done) begin
            wait_cnt <= '0;
         end else if (state_q == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (tmo_fire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign mem_req_we    = lat_we;
   assign mem_req_addr  = lat_addr;
   assign mem_req_wdata = lat_wdata;
   assign busy          = (state_q != IDLE);
   // The flag shows in the timing-out cycle itself, then stays set from the register.
   assign timeout_err   = timeout_q | tmo_fire;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: grant order, write hold, timeout, spurious responses, async reset.
module tb_mem_req_arbiter;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    resp_valid;
   logic [DW-1:0]   resp_data;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_we;
   logic [AW-1:0]   mem_req_addr;
   logic [DW-1:0]   mem_req_wdata;
   logic            mem_resp_valid;
   logic [DW-1:0]   mem_resp_data;
   logic            busy;
   logic            timeout_err;

   int checks   = 0;
   int failures = 0;

   mem_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic early;
      int   g;
      rst            = 1'b1;
      req_valid      = 3'b111;
      req_we         = '0;
      req_addr       = '0;
      req_wdata      = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      tick;
      tick;
      // Reset state, with requests already pending
      check("rst_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_mem_vld", mem_req_valid, 0);
      check("rst_mem_we", mem_req_we, 0);
      check("rst_mem_addr", mem_req_addr, 0);
      check("rst_mem_wdata", mem_req_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout_err, 0);
      req_valid = '0;
      tick;

      // Single read from requester 1
      rst = 1'b0;
      req_addr[1*AW +: AW] = 32'h0000_1000;
      req_valid = 3'b010;
      #1;
      check("t1_ready", req_ready, 3'b010);
      check("t1_memvld_T", mem_req_valid, 0);
      tick;
      req_valid = '0;
      mem_req_ready = 1'b1;
      #1;
      check("t1_memvld", mem_req_valid, 1);
      check("t1_addr", mem_req_addr, 32'h0000_1000);
      check("t1_we", mem_req_we, 0);
      check("t1_busy", busy, 1);
      tick;
      mem_req_ready = 1'b0;
      #1;
      check("t1_noresp", resp_valid, 0);
      tick;
      tick;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_BEEF;
      #1;
      check("t1_resp_valid", resp_valid, 3'b010);
      check("t1_resp_data", resp_data, 32'hDEAD_BEEF);
      tick;
      mem_resp_valid = 1'b0;
      #1;
      check("t1_busy_done", busy, 0);
      check("t1_resp_idle", resp_data, 0);

      // Round-robin with all three requesting continuously from reset
      tick;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'hA000 + 32'(i * 16);
      req_valid = 3'b111;
      mem_req_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         g = k % 3;
         #1;
         check("rr_grant", req_ready, 64'(1 << g));
         tick;
         #1;
         check("rr_addr", mem_req_addr, 64'(32'hA000 + g * 16));
         tick;
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'hC0DE_0000 + 32'(k);
         #1;
         check("rr_resp_valid", resp_valid, 64'(1 << g));
         check("rr_resp_data", resp_data, 64'(32'hC0DE_0000 + k));
         tick;
         mem_resp_valid = 1'b0;
      end
      req_valid = '0;
      mem_req_ready = 1'b0;

      // Posted write from requester 2 with memory backpressure
      req_we = 3'b100;
      req_addr[2*AW +: AW]  = 32'h0000_2000;
      req_wdata[2*DW +: DW] = 32'h1234_5678;
      req_valid = 3'b100;
      #1;
      check("t3_ready", req_ready, 3'b100);
      tick;
      req_valid = '0;
      req_we = '0;
      for (int k = 0; k < 5; k++) begin
         mem_req_ready = (k == 4);
         #1;
         check("t3_hold_vld", mem_req_valid, 1);
         check("t3_hold_we", mem_req_we, 1);
         check("t3_hold_addr", mem_req_addr, 32'h0000_2000);
         check("t3_hold_wdata", mem_req_wdata, 32'h1234_5678);
         tick;
      end
      mem_req_ready = 1'b0;
      #1;
      check("t3_idle", busy, 0);
      check("t3_no_resp", resp_valid, 0);
      tick;
      #1;
      check("t3_no_resp2", resp_valid, 0);
      check("t3_memvld_off", mem_req_valid, 0);

      // Spurious memory responses in IDLE and ISSUE
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hAAAA_5555;
      #1;
      check("t5_idle_resp", resp_valid, 0);
      check("t5_idle_data", resp_data, 0);
      tick;
      #1;
      check("t5_idle_busy", busy, 0);
      req_addr[0*AW +: AW] = 32'h0000_3000;
      req_valid = 3'b001;
      #1;
      check("t5_ready", req_ready, 3'b001);
      tick;
      req_valid = '0;
      #1;
      check("t5_issue_resp", resp_valid, 0);
      check("t5_issue_vld", mem_req_valid, 1);
      tick;
      #1;
      check("t5_issue_hold", mem_req_valid, 1);
      check("t5_issue_data", resp_data, 0);

      // Read with no response until the latency bound
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      early = 1'b0;
      for (int n = 1; n < 255; n++) begin
         #1;
         if (resp_valid != 0 || timeout_err || !busy) early = 1'b1;
         tick;
      end
      #1;
      check("t4_early", early, 0);
      check("t4_resp_valid", resp_valid, 3'b001);
      check("t4_resp_data", resp_data, 0);
      check("t4_timeout", timeout_err, 1);
      tick;
      #1;
      check("t4_idle", busy, 0);
      check("t4_sticky", timeout_err, 1);
      req_valid = 3'b010;
      tick;
      req_valid = '0;
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_0077;
      #1;
      check("t4_next_resp", resp_valid, 3'b010);
      check("t4_sticky2", timeout_err, 1);
      tick;
      mem_resp_valid = 1'b0;

      // Async reset in WAIT, stale response afterwards, rr_ptr back to 0
      req_valid = 3'b010;
      #1;
      check("t6_ready", req_ready, 3'b010);
      tick;
      req_valid = '0;
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      tick;
      #1;
      rst = 1'b1;
      #1;
      check("t6_busy", busy, 0);
      check("t6_memvld", mem_req_valid, 0);
      check("t6_memaddr", mem_req_addr, 0);
      check("t6_timeout", timeout_err, 0);
      check("t6_resp", resp_valid, 0);
      tick;
      rst = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_0BAD;
      #1;
      check("t6_stale", resp_valid, 0);
      check("t6_stale_busy", busy, 0);
      tick;
      mem_resp_valid = 1'b0;
      req_valid = 3'b110;
      #1;
      check("t6_ptr0", req_ready, 3'b010);

      // Response arriving exactly at the latency bound wins
      tick;
      req_valid = '0;
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      for (int n = 1; n < 255; n++) tick;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_55AA;
      #1;
      check("t7_resp_valid", resp_valid, 3'b010);
      check("t7_resp_data", resp_data, 32'h0000_55AA);
      check("t7_no_timeout", timeout_err, 0);
      tick;
      mem_resp_valid = 1'b0;
      #1;
      check("t7_no_timeout2", timeout_err, 0);
      check("t7_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
